tpu_systolic: RTL and testbench
===============================

// Module: tpu_systolic
// PURPOSE
//  4x4 weight-stationary systolic matrix-multiply unit (MMU) for the brightness-filter datapath.
//  Weights are shifted in column-parallel and then held. Data streams left->right along rows.
//  Partial sums flow top->bottom. Bottom-row sums are exported raw (40b) and clamped to pixel
//  range (16b).
// PARAMETERS
//  bit_width  16  width of data/weight elements, signed two's complement
//  acc_width  40  width of partial sums/accumulators, signed
//  DEPTH      4   array rows = columns (fixed at 4; ports are sized for 4)
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            synchronous active-high reset
//  control        in   1            1 = weight-load phase, 0 = compute phase
//  data_arr       in   64           row inputs; slice i = [16i+15:16i] feeds PE(i,0)
//  wt_arr         in   64           weight vector; slice j = [16j+15:16j] feeds column j
//  acc_out        out  160          {pe33_out,pe32_out,pe31_out,pe30_out}
//  pe30..pe33_out out  40 each      registered partial sum of PE(3,j) (column j result)
//  pe30..33_norm_out out 16 each    pe3j_out clamped to 0..255, zero-extended
// BEHAVIOUR
//  - Internal arrays: wt_out[i][j] (PE weight), data_out[i][j] (forwarded data), psum[i][j];
//    all 16/16/40 bits.
//  - Reset (rst=1 at posedge): every wt_out, data_out and psum is cleared to 0, so all outputs
//    are 0. Reset has priority over control; reset mid-load or mid-compute discards all state.
//  - control=1 (load), each posedge:
//    - wt_out[0][j] <= wt_arr slice j; wt_out[i][j] <= wt_out[i-1][j] for i=1..3.
//    - data_out and psum are cleared to 0.
//    - After 4 load cycles, row r holds the vector presented 3-r cycles before the last load.
//      The vector intended for row 3 is presented first.
//  - control=0 (compute), each posedge, per PE(i,j):
//    - Weights hold.
//    - data_in = data_arr slice i (j=0) else data_out[i][j-1]; data_out[i][j] <= data_in.
//    - psum_in = 0 (i=0) else psum[i-1][j].
//    - psum[i][j] <= psum_in + sext40(wt_out[i][j]*data_in). The product is a signed 16x16->32b
//      result, sign-extended to 40b. Addition wraps modulo 2^40 (no saturation).
//  - Timing/skew:
//    - The caller presents element i of input vector t on slice i at edge t+i (diagonal feed).
//    - PE(i,j) consumes it at edge t+i+j.
//    - pe3j_out holds sum_i W[i][j]*x_t[i] after edge t+3+j (latency 4+j cycles from the row-0
//      element).
//    - A new vector may start every cycle (full throughput).
//  - pe3j_out = psum[3][j] (registered, no extra stage). acc_out is the same values concatenated.
//  - norm: 0 if pe3j_out<0; 255 if pe3j_out>255; else pe3j_out[15:0]. Combinational from pe3j_out.
//  - Switching control 0->1 clears in-flight sums on the next edge. Switching 1->0 starts compute
//    on the next edge with the weights as loaded.
//  - X/undriven data lanes are not propagated meaningfully. Callers drive 0 on idle lanes.
// TESTING
//  1. Reset: rst=1 one cycle with random inputs -> all pe3j_out, acc_out, norm outputs = 0.
//  2. Identity load:
//     - control=1, wt_arr = 0001_0000_0000_0000, 0000_0001_0000_0000, 0000_0000_0001_0000,
//       0000_0000_0000_0001 on 4 edges -> wt_out[k][k]=1, others 0.
//  3. Identity compute:
//     - Skewed feed of x=[1,2,3,4] with zeros elsewhere -> pe30..33_out = 1,2,3,4.
//     - pe3j_out is valid after edge t+3+j; norm outputs equal the same values.
//  4. Signed/dense:
//     - All weights = 0xFFFF (-1), x=[3,5,7,9] -> every pe3j_out = -24 (0xFFFFFFFFE8), norm = 0.
//  5. Saturation:
//     - W all 0x0040 (64), x=[1,1,1,1] -> pe3j_out = 256, norm = 255.
//     - x=[1,0,0,1] -> 128, norm = 128.
//  6. Streaming/reload:
//     - Back-to-back vectors [1,2,3,4] then [4,3,2,1] under identity -> consecutive correct
//       results.
//     - Then control=1 for one edge -> all psum cleared to 0 next cycle.

Source files
------------

// File: rtl/tpu_systolic_if.sv
// Bus bundle for the 4x4 systolic matrix-multiply unit.
//   control        1 = weight-load phase, 0 = compute phase
//   data_arr       row inputs, slice i = [16i+15:16i] feeds row i
//   wt_arr         weight vector, slice j = [16j+15:16j] feeds column j
//   acc_out        {pe33_out, pe32_out, pe31_out, pe30_out}
//   pe3j_out       raw 40-bit column results (bottom-row partial sums)
//   pe3j_norm_out  column results clamped to 0..255, zero-extended to 16 bits
// master drives control/data/weights; slave (the array) drives the results.
interface tpu_systolic_if;
  logic         control;
  logic [63:0]  data_arr;
  logic [63:0]  wt_arr;
  logic [159:0] acc_out;
  logic [39:0]  pe30_out;
  logic [39:0]  pe31_out;
  logic [39:0]  pe32_out;
  logic [39:0]  pe33_out;
  logic [15:0]  pe30_norm_out;
  logic [15:0]  pe31_norm_out;
  logic [15:0]  pe32_norm_out;
  logic [15:0]  pe33_norm_out;

  modport master (
    output control, data_arr, wt_arr,
    input  acc_out, pe30_out, pe31_out, pe32_out, pe33_out,
    input  pe30_norm_out, pe31_norm_out, pe32_norm_out, pe33_norm_out
  );

  modport slave (
    input  control, data_arr, wt_arr,
    output acc_out, pe30_out, pe31_out, pe32_out, pe33_out,
    output pe30_norm_out, pe31_norm_out, pe32_norm_out, pe33_norm_out
  );
endinterface

// File: rtl/tpu_systolic.sv
// 4x4 weight-stationary systolic matrix-multiply unit.
// Weights shift in top->bottom during the load phase and are then held; data
// streams left->right along rows, partial sums flow top->bottom. The bottom row
// sums are exported raw (40b) and clamped to pixel range (0..255).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, priority over control
//   bus  tpu_systolic_if.slave (control, data_arr, wt_arr in; results out)
module tpu_systolic #(
  parameter int bit_width = 16,
  parameter int acc_width = 40,
  parameter int DEPTH     = 4
) (
  input  logic          clk,
  input  logic          rst,
  tpu_systolic_if.slave bus
);

  localparam int prod_width = 2 * bit_width;

  logic signed [bit_width-1:0]  wt_out   [DEPTH][DEPTH];
  logic signed [bit_width-1:0]  data_out [DEPTH][DEPTH];
  logic signed [acc_width-1:0]  psum     [DEPTH][DEPTH];

  logic signed [bit_width-1:0]  data_in  [DEPTH][DEPTH];
  logic signed [acc_width-1:0]  psum_in  [DEPTH][DEPTH];
  logic signed [prod_width-1:0] prod     [DEPTH][DEPTH];

  // PE input muxing: column 0 takes the external row lane, other columns the
  // left neighbour; row 0 starts its sum at 0, other rows take the PE above.
  // NOTE: every element is written on every pass of this block, so no latch
  // is inferred even though the assignments are spread across loops.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      data_in[i][0] = bus.data_arr[bit_width*i +: bit_width];
      for (int j = 1; j < DEPTH; j++) begin
        data_in[i][j] = data_out[i][j-1];
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      psum_in[0][j] = '0;
      for (int i = 1; i < DEPTH; i++) begin
        psum_in[i][j] = psum[i-1][j];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        prod[i][j] = wt_out[i][j] * data_in[i][j];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every PE
  // samples its neighbours' pre-edge values and the array shifts by exactly
  // one position per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register arrays are reset explicitly: a reset mid-load or
      // mid-compute must leave no stale weights or partial sums behind.
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          wt_out[i][j]   <= '0;
          data_out[i][j] <= '0;
          psum[i][j]     <= '0;
        end
      end
    end else if (bus.control) begin
      // Load: the weight vector enters row 0 and ripples downward, so the
      // vector for row 3 must be presented first. In-flight data is flushed.
      for (int j = 0; j < DEPTH; j++) begin
        wt_out[0][j] <= bus.wt_arr[bit_width*j +: bit_width];
        for (int i = 1; i < DEPTH; i++) begin
          wt_out[i][j] <= wt_out[i-1][j];
        end
        for (int i = 0; i < DEPTH; i++) begin
          data_out[i][j] <= '0;
          psum[i][j]     <= '0;
        end
      end
    end else begin
      // Compute: weights hold; the 32-bit signed product is sign-extended to
      // the accumulator width and added with plain wrap-around.
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          data_out[i][j] <= data_in[i][j];
          psum[i][j]     <= psum_in[i][j] +
                            {{(acc_width-prod_width){prod[i][j][prod_width-1]}}, prod[i][j]};
        end
      end
    end
  end

  function automatic logic [15:0] clamp_pixel(input logic signed [acc_width-1:0] v);
    if (v < 0)
      return 16'd0;
    else if (v > 255)
      return 16'd255;
    else
      return v[15:0];
  endfunction

  assign bus.pe30_out = psum[DEPTH-1][0];
  assign bus.pe31_out = psum[DEPTH-1][1];
  assign bus.pe32_out = psum[DEPTH-1][2];
  assign bus.pe33_out = psum[DEPTH-1][3];
  assign bus.acc_out  = {psum[DEPTH-1][3], psum[DEPTH-1][2], psum[DEPTH-1][1], psum[DEPTH-1][0]};

  assign bus.pe30_norm_out = clamp_pixel(psum[DEPTH-1][0]);
  assign bus.pe31_norm_out = clamp_pixel(psum[DEPTH-1][1]);
  assign bus.pe32_norm_out = clamp_pixel(psum[DEPTH-1][2]);
  assign bus.pe33_norm_out = clamp_pixel(psum[DEPTH-1][3]);

endmodule

// File: tb/tb_tpu_systolic.sv
// Self-checking bench for tpu_systolic: a table of weight matrices, input
// vectors and hand-computed column results, plus directed sequences for
// reset, mid-operation reset, back-to-back streaming and reload flush.
module tb_tpu_systolic;

  typedef logic [3:0][3:0][15:0] wmat_t;   // [row][col]
  typedef struct packed {
    wmat_t             w;
    logic [3:0][15:0]  x;
    logic [3:0][39:0]  exp_out;
    logic [3:0][15:0]  exp_norm;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpu_systolic_if bus ();

  tpu_systolic dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] col_out(input int j);
    case (j)
      0:       return bus.pe30_out;
      1:       return bus.pe31_out;
      2:       return bus.pe32_out;
      default: return bus.pe33_out;
    endcase
  endfunction

  function automatic logic [15:0] col_norm(input int j);
    case (j)
      0:       return bus.pe30_norm_out;
      1:       return bus.pe31_norm_out;
      2:       return bus.pe32_norm_out;
      default: return bus.pe33_norm_out;
    endcase
  endfunction

  task automatic check_col(input string tag, input int j, input logic [39:0] exp,
                           input logic [15:0] expn);
    check($sformatf("%s pe3%0d_out", tag, j), col_out(j), exp);
    check($sformatf("%s pe3%0d_norm_out", tag, j), {24'd0, col_norm(j)}, {24'd0, expn});
    check($sformatf("%s acc_out[%0d]", tag, j), bus.acc_out[40*j +: 40], exp);
  endtask

  task automatic check_all_zero(input string tag);
    for (int j = 0; j < 4; j++) check_col(tag, j, 40'd0, 16'd0);
  endtask

  // Row 3's vector goes in first; after four load edges row r holds w[r].
  task automatic load_weights(input wmat_t w);
    bus.data_arr = '0;
    for (int r = 3; r >= 0; r--) begin
      bus.control = 1'b1;
      for (int j = 0; j < 4; j++) bus.wt_arr[16*j +: 16] = w[r][j];
      step();
    end
    bus.control = 1'b0;
    bus.wt_arr  = '0;
  endtask

  // Single vector fed diagonally from edge 0; column j is checked to still be
  // zero after edge 2+j and to hold its result after edge 3+j.
  task automatic run_vec(input string tag, input vec_t v);
    for (int e = 0; e < 7; e++) begin
      for (int i = 0; i < 4; i++) bus.data_arr[16*i +: 16] = (e == i) ? v.x[i] : 16'd0;
      step();
      for (int j = 0; j < 4; j++) begin
        if (e == 2 + j) check($sformatf("%s early pe3%0d_out", tag, j), col_out(j), 40'd0);
        if (e == 3 + j) check_col(tag, j, v.exp_out[j], v.exp_norm[j]);
      end
    end
    bus.data_arr = '0;
  endtask

  function automatic wmat_t ident();
    wmat_t w = '0;
    for (int k = 0; k < 4; k++) w[k][k] = 16'd1;
    return w;
  endfunction

  function automatic wmat_t fill(input logic [15:0] val);
    wmat_t w;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) w[r][j] = val;
    return w;
  endfunction

  // 2 on the diagonal, -1 just right of it: column j = 2*x[j] - x[j-1].
  function automatic wmat_t bidiag();
    wmat_t w = '0;
    for (int k = 0; k < 4; k++) begin
      w[k][k] = 16'd2;
      if (k < 3) w[k][k+1] = 16'hFFFF;
    end
    return w;
  endfunction

  function automatic vec_t mk(input wmat_t w,
                              input logic [15:0] x0, x1, x2, x3,
                              input logic [39:0] e0, e1, e2, e3,
                              input logic [15:0] n0, n1, n2, n3);
    vec_t v;
    v.w = w;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.exp_out[0] = e0; v.exp_out[1] = e1; v.exp_out[2] = e2; v.exp_out[3] = e3;
    v.exp_norm[0] = n0; v.exp_norm[1] = n1; v.exp_norm[2] = n2; v.exp_norm[3] = n3;
    return v;
  endfunction

  vec_t vecs [7];

  initial begin
    vecs[0] = mk(ident(), 16'd1, 16'd2, 16'd3, 16'd4,
                 40'd1, 40'd2, 40'd3, 40'd4, 16'd1, 16'd2, 16'd3, 16'd4);
    vecs[1] = mk(fill(16'hFFFF), 16'd3, 16'd5, 16'd7, 16'd9,
                 40'hFF_FFFF_FFE8, 40'hFF_FFFF_FFE8, 40'hFF_FFFF_FFE8, 40'hFF_FFFF_FFE8,
                 16'd0, 16'd0, 16'd0, 16'd0);
    vecs[2] = mk(fill(16'h0040), 16'd1, 16'd1, 16'd1, 16'd1,
                 40'd256, 40'd256, 40'd256, 40'd256, 16'd255, 16'd255, 16'd255, 16'd255);
    vecs[3] = mk(fill(16'h0040), 16'd1, 16'd0, 16'd0, 16'd1,
                 40'd128, 40'd128, 40'd128, 40'd128, 16'd128, 16'd128, 16'd128, 16'd128);
    vecs[4] = mk(ident(), 16'd300, 16'hFFFB, 16'd0, 16'd255,
                 40'd300, 40'hFF_FFFF_FFFB, 40'd0, 40'd255, 16'd255, 16'd0, 16'd0, 16'd255);
    vecs[5] = mk(bidiag(), 16'd10, 16'd20, 16'd30, 16'd40,
                 40'd20, 40'd30, 40'd40, 40'd50, 16'd20, 16'd30, 16'd40, 16'd50);
    // (-32768)^2 * 4 = 2^32: only correct if the product is sign-extended past 32 bits.
    vecs[6] = mk(fill(16'h8000), 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 40'h01_0000_0000, 40'h01_0000_0000, 40'h01_0000_0000, 40'h01_0000_0000,
                 16'd255, 16'd255, 16'd255, 16'd255);

    // Reset with random inputs on the bus.
    rst          = 1'b1;
    bus.control  = 1'($urandom_range(0, 1));
    bus.data_arr = {$urandom(), $urandom()};
    bus.wt_arr   = {$urandom(), $urandom()};
    step();
    check_all_zero("reset");
    rst          = 1'b0;
    bus.control  = 1'b0;
    bus.data_arr = '0;
    bus.wt_arr   = '0;

    // Table-driven vectors: reload weights, then one diagonal feed.
    for (int k = 0; k < 7; k++) begin
      load_weights(vecs[k].w);
      run_vec($sformatf("vec%0d", k), vecs[k]);
    end

    // Back-to-back vectors A=[1,2,3,4] (t=0) and B=[4,3,2,1] (t=1) under identity.
    load_weights(ident());
    for (int e = 0; e < 8; e++) begin
      for (int i = 0; i < 4; i++) begin
        if (e == i)          bus.data_arr[16*i +: 16] = 16'(i + 1);
        else if (e == i + 1) bus.data_arr[16*i +: 16] = 16'(4 - i);
        else                 bus.data_arr[16*i +: 16] = 16'd0;
      end
      step();
      for (int j = 0; j < 4; j++) begin
        if (e == 3 + j) check_col("stream A", j, 40'(j + 1), 16'(j + 1));
        if (e == 4 + j) check_col("stream B", j, 40'(4 - j), 16'(4 - j));
      end
    end
    bus.data_arr = '0;

    // One load edge while sums are in flight flushes every partial sum.
    load_weights(ident());
    for (int e = 0; e < 5; e++) begin
      for (int i = 0; i < 4; i++) bus.data_arr[16*i +: 16] = (e == i) ? 16'(i + 1) : 16'd0;
      step();
    end
    check_col("pre-flush", 1, 40'd2, 16'd2);
    bus.data_arr = '0;
    bus.control  = 1'b1;
    step();
    bus.control  = 1'b0;
    check_all_zero("flush");

    // Reset mid-compute discards the weights too: a later feed yields zeros.
    load_weights(ident());
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < 4; i++) bus.data_arr[16*i +: 16] = (e == i) ? 16'(i + 1) : 16'd0;
      step();
    end
    check_col("pre-reset", 0, 40'd1, 16'd1);
    rst = 1'b1;
    step();
    check_all_zero("mid reset");
    rst = 1'b0;
    run_vec("after reset", mk(ident(), 16'd1, 16'd2, 16'd3, 16'd4,
                              40'd0, 40'd0, 40'd0, 40'd0, 16'd0, 16'd0, 16'd0, 16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
